// File: rtl/nine_bit_div_pkg.sv
// Shared types and default widths for the 9-bit divider control stage.
package nine_bit_div_pkg;

    localparam int unsigned CW_DEF = 9;
    localparam int unsigned PW_DEF = 8;
    // Toggle count runs to 2*periods, which needs one bit more than periods
    localparam int unsigned TW_DEF = PW_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/nine_bit_divider_ctrl_if.sv
// Handshake/data bundle between the divider control, its requester and the counter.
interface nine_bit_divider_ctrl_if
    import nine_bit_div_pkg::*;
#(
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned PW = PW_DEF
);
    logic          start;
    logic          abort;
    logic [CW-1:0] preset;
    logic [PW-1:0] periods;
    logic          cnt_cout;
    logic          cnt_ld;
    logic [CW-1:0] cnt_par;
    logic          wave_out;
    logic          busy;
    logic          done;

    modport master (
        output start, abort, preset, periods, cnt_cout,
        input  cnt_ld, cnt_par, wave_out, busy, done
    );

    modport slave (
        input  start, abort, preset, periods, cnt_cout,
        output cnt_ld, cnt_par, wave_out, busy, done
    );
endinterface

// File: rtl/div_toggle_counter.sv
// Counts carry-outs of a burst, flags the final one and owns the square-wave flop.
module div_toggle_counter
    import nine_bit_div_pkg::*;
#(
    parameter int unsigned TW = TW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic          wave_clr,
    input  logic [TW-1:0] target,
    output logic          last_c,
    output logic          wave
);
    logic [TW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + TW'(1);
        end
    end

    // True when the pending increment reaches the burst's toggle target
    assign last_c = ((count + TW'(1)) == target);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wave <= 1'b0;
        end else if (clr || wave_clr) begin
            wave <= 1'b0;
        end else if (inc) begin
            wave <= ~wave;
        end
    end

endmodule

// File: rtl/nine_bit_divider_ctrl.sv
// Drives a 9-bit loadable up-counter as a programmable divider and runs bursts of output periods.
module nine_bit_divider_ctrl
    import nine_bit_div_pkg::*;
#(
    parameter int unsigned CW = CW_DEF,
    parameter int unsigned PW = PW_DEF
) (
    input logic               clk,
    input logic               rst,
    nine_bit_divider_ctrl_if.slave bus
);
    localparam int unsigned TW = PW + 1;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] preset_q;
    logic [PW-1:0] periods_q;
    logic          load_cfg;
    logic          tog_clr;
    logic          tog_inc;
    logic          wave_clr;
    logic          last_c;
    logic          wave;
    logic [TW-1:0] target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        load_cfg = 1'b0;
        tog_clr  = 1'b0;
        tog_inc  = 1'b0;
        wave_clr = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load_cfg = 1'b1;
                    tog_clr  = 1'b1;
                    state_n  = (bus.periods == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    wave_clr = 1'b1;
                    state_n  = IDLE;
                end else begin
                    state_n  = RUN;
                end
            end
            RUN: begin
                // Abort wins over a coincident carry: no toggle, no completion
                if (bus.abort) begin
                    wave_clr = 1'b1;
                    state_n  = IDLE;
                end else if (bus.cnt_cout) begin
                    tog_inc = 1'b1;
                    if (last_c) begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                wave_clr = 1'b1;
                state_n  = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            preset_q  <= '0;
            periods_q <= '0;
        end else if (load_cfg) begin
            preset_q  <= bus.preset;
            periods_q <= bus.periods;
        end
    end

    assign target = TW'({periods_q, 1'b0});

    div_toggle_counter #(
        .TW(TW)
    ) u_toggle (
        .clk      (clk),
        .rst      (rst),
        .clr      (tog_clr),
        .inc      (tog_inc),
        .wave_clr (wave_clr),
        .target   (target),
        .last_c   (last_c),
        .wave     (wave)
    );

    // In RUN the counter free-runs and reloads only on the edge after its wrap
    assign bus.cnt_ld   = (state == RUN) ? bus.cnt_cout : 1'b1;
    assign bus.cnt_par  = preset_q;
    assign bus.wave_out = wave;
    assign bus.busy     = (state == LOAD) || (state == RUN);
    assign bus.done     = (state == DONE);

endmodule
